// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
// Owns the external 512Kx8 SRAM and shares it between the acquisition write
// port, the MCU write port and the MCU read port (fixed priority
// ACQ > MCU_WR > MCU_RD). Sequences OE/WE/data-bus timing, keeps the
// auto-incrementing, saturating address counter and reports EMPTY/FULL/BUSY.
//
// Ports:
//   CLOCK, RESET_n              master clock, asynchronous active-low reset
//   ACQ_WR_REQ/DATA/ACK         acquisition write port (level req, pulse ack)
//   MCU_WR_REQ/DATA/ACK         MCU write port (level req, pulse ack)
//   MCU_RD_REQ/DATA/ACK         MCU read port; data valid from the ack cycle
//   ADDR_LOAD, ADDR_LOAD_VAL    one-cycle address load strobe and value
//   SRAM_A, SRAM_DQ_OUT,
//   SRAM_DQ_IN, SRAM_DQ_OE,
//   SRAM_WE_n, SRAM_OE_n        SRAM pin-side signals
//   EMPTY, FULL, BUSY           status bits
//   DROP_COUNT                  dropped acquisition writes (optional)
//
// Optional feature macro: SRAM_ARB_DROP_COUNT_EN
//   defined   -> DROP_COUNT is an 8-bit saturating count of dropped writes
//   undefined -> DROP_COUNT is tied to zero
// -----------------------------------------------------------------------------
module sram_arbiter #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 8,
  parameter int WE_CYCLES  = 1
) (
  input  logic                  CLOCK,
  input  logic                  RESET_n,
  input  logic                  ACQ_WR_REQ,
  input  logic [DATA_WIDTH-1:0] ACQ_WR_DATA,
  output logic                  ACQ_WR_ACK,
  input  logic                  MCU_WR_REQ,
  input  logic [DATA_WIDTH-1:0] MCU_WR_DATA,
  output logic                  MCU_WR_ACK,
  input  logic                  MCU_RD_REQ,
  output logic [DATA_WIDTH-1:0] MCU_RD_DATA,
  output logic                  MCU_RD_ACK,
  input  logic                  ADDR_LOAD,
  input  logic [ADDR_WIDTH-1:0] ADDR_LOAD_VAL,
  output logic [ADDR_WIDTH-1:0] SRAM_A,
  output logic [DATA_WIDTH-1:0] SRAM_DQ_OUT,
  input  logic [DATA_WIDTH-1:0] SRAM_DQ_IN,
  output logic                  SRAM_DQ_OE,
  output logic                  SRAM_WE_n,
  output logic                  SRAM_OE_n,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic                  BUSY,
  output logic [7:0]            DROP_COUNT
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_WAIT  = 3'd1,
    ST_WR_TURN  = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_END   = 3'd4
  } state_t;

  localparam logic [3:0]            WE_LAST  = 4'(WE_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_r;
  logic [3:0]              we_cnt_r;
  logic                    src_acq_r;   // current write belongs to the acquisition port
  logic                    drop_r;      // current acquisition write is dropped
  logic                    top_used_r;  // top location already consumed by an access
  logic                    pend_r;
  logic [ADDR_WIDTH-1:0]   pend_val_r;
  logic                    ack_edge_s;
  logic                    apply_s;
  logic [ADDR_WIDTH-1:0]   load_val_s;

  assign EMPTY = (SRAM_A == {ADDR_WIDTH{1'b0}});
  assign FULL  = (SRAM_A == ADDR_MAX);

  // The clock edge on which a transaction acks is also where its increment
  // happens; a load (fresh or pending) replaces the increment there, and a
  // load arriving during WR_END is applied on the way back to IDLE.
  assign ack_edge_s = (state_r == ST_RD_WAIT) ||
                      ((state_r == ST_WR_PULSE) && (we_cnt_r == WE_LAST));
  assign apply_s    = ((state_r == ST_IDLE) && ADDR_LOAD) ||
                      ((ack_edge_s || (state_r == ST_WR_END)) && (ADDR_LOAD || pend_r));
  assign load_val_s = ADDR_LOAD ? ADDR_LOAD_VAL : pend_val_r;

  // Arbitration FSM, address counter and all registered SRAM-side outputs.
  always_ff @(posedge CLOCK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_r     <= ST_IDLE;
      we_cnt_r    <= 4'd0;
      src_acq_r   <= 1'b0;
      drop_r      <= 1'b0;
      top_used_r  <= 1'b0;
      pend_r      <= 1'b0;
      pend_val_r  <= {ADDR_WIDTH{1'b0}};
      SRAM_A      <= {ADDR_WIDTH{1'b0}};
      SRAM_DQ_OUT <= {DATA_WIDTH{1'b0}};
      SRAM_DQ_OE  <= 1'b0;
      SRAM_WE_n   <= 1'b1;
      SRAM_OE_n   <= 1'b0;
      MCU_RD_DATA <= {DATA_WIDTH{1'b0}};
      ACQ_WR_ACK  <= 1'b0;
      MCU_WR_ACK  <= 1'b0;
      MCU_RD_ACK  <= 1'b0;
      BUSY        <= 1'b0;
    end else begin
      ACQ_WR_ACK <= 1'b0;
      MCU_WR_ACK <= 1'b0;
      MCU_RD_ACK <= 1'b0;

      if (apply_s) begin
        SRAM_A <= load_val_s;
        pend_r <= 1'b0;
      end else if (ADDR_LOAD) begin
        pend_r     <= 1'b1;
        pend_val_r <= ADDR_LOAD_VAL;
      end

      // FULL marks the last location rather than past-the-end: the top
      // location is still accessed once, after which acquisition writes drop.
      if (apply_s) begin
        top_used_r <= 1'b0;
      end else if (ack_edge_s && FULL) begin
        top_used_r <= 1'b1;
      end

      case (state_r)
        ST_IDLE: begin
          if (ADDR_LOAD) begin
            state_r <= ST_IDLE;   // load goes first, request waits a cycle
          end else if (ACQ_WR_REQ) begin
            state_r     <= ST_WR_TURN;
            src_acq_r   <= 1'b1;
            drop_r      <= top_used_r;
            SRAM_DQ_OUT <= ACQ_WR_DATA;
            SRAM_OE_n   <= 1'b1;
            BUSY        <= 1'b1;
          end else if (MCU_WR_REQ) begin
            state_r     <= ST_WR_TURN;
            src_acq_r   <= 1'b0;
            drop_r      <= 1'b0;
            SRAM_DQ_OUT <= MCU_WR_DATA;
            SRAM_OE_n   <= 1'b1;
            BUSY        <= 1'b1;
          end else if (MCU_RD_REQ) begin
            state_r <= ST_RD_WAIT;
            BUSY    <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RD_WAIT: begin
          state_r     <= ST_IDLE;
          MCU_RD_DATA <= SRAM_DQ_IN;
          MCU_RD_ACK  <= 1'b1;
          BUSY        <= 1'b0;
          if (!apply_s && !FULL) SRAM_A <= SRAM_A + ADDR_ONE;
        end
        ST_WR_TURN: begin
          state_r    <= ST_WR_PULSE;
          SRAM_DQ_OE <= 1'b1;
          SRAM_WE_n  <= drop_r;   // a dropped write never strobes WE
          we_cnt_r   <= 4'd0;
        end
        ST_WR_PULSE: begin
          if (we_cnt_r == WE_LAST) begin
            state_r   <= ST_WR_END;
            SRAM_WE_n <= 1'b1;
            if (src_acq_r) ACQ_WR_ACK <= 1'b1;
            else           MCU_WR_ACK <= 1'b1;
            if (!apply_s && !drop_r && !FULL) SRAM_A <= SRAM_A + ADDR_ONE;
          end else begin
            we_cnt_r <= we_cnt_r + 4'd1;
          end
        end
        ST_WR_END: begin
          state_r    <= ST_IDLE;
          SRAM_OE_n  <= 1'b0;
          SRAM_DQ_OE <= 1'b0;
          BUSY       <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          SRAM_WE_n  <= 1'b1;
          SRAM_OE_n  <= 1'b0;
          SRAM_DQ_OE <= 1'b0;
          BUSY       <= 1'b0;
        end
      endcase
    end
  end

`ifdef SRAM_ARB_DROP_COUNT_EN
  logic drop_inc_s;
  assign drop_inc_s = (state_r == ST_WR_PULSE) && (we_cnt_r == WE_LAST) && drop_r;

  // Saturating count of dropped acquisition writes; an applied load clears it.
  always_ff @(posedge CLOCK or negedge RESET_n) begin
    if (!RESET_n) begin
      DROP_COUNT <= 8'd0;
    end else if (apply_s) begin
      DROP_COUNT <= 8'd0;
    end else if (drop_inc_s && (DROP_COUNT != 8'd255)) begin
      DROP_COUNT <= DROP_COUNT + 8'd1;
    end
  end
`else
  assign DROP_COUNT = 8'd0;
`endif

endmodule
